// File: rtl/matrix_mult_scheduler.sv
// rtl/matrix_mult_scheduler.sv - walks an N x N product through one shared inner_product engine
// Optional per-element watchdog: define SCHED_TIMEOUT_EN.
module matrix_mult_scheduler #(
  parameter int N = 4,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT = 1024,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int AW = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IW-1:0]         row_sel,
  output logic [IW-1:0]         col_sel,
  output logic                  ip_row_stb,
  output logic                  ip_col_stb,
  input  logic                  ip_row_ack,
  input  logic                  ip_col_ack,
  output logic                  ip_out_ack,
  input  logic                  ip_out_stb,
  input  logic [WORD_WIDTH-1:0] ip_out,
  output logic                  res_we,
  output logic [AW-1:0]         res_addr,
  output logic [WORD_WIDTH-1:0] res_data,
  input  logic                  res_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, WRITE, DONE} state_t;

  state_t state;
  logic   row_got;
  logic   col_got;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      row_sel    <= '0;
      col_sel    <= '0;
      ip_row_stb <= 1'b0;
      ip_col_stb <= 1'b0;
      ip_out_ack <= 1'b0;
      res_we     <= 1'b0;
      res_addr   <= '0;
      res_data   <= '0;
      row_got    <= 1'b0;
      col_got    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_sel    <= '0;
            col_sel    <= '0;
            res_addr   <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            ip_row_stb <= 1'b1;
            ip_col_stb <= 1'b1;
            ip_out_ack <= 1'b1;
            row_got    <= 1'b0;
            col_got    <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (ip_row_ack) begin
            row_got    <= 1'b1;
            ip_row_stb <= 1'b0;
          end
          if (ip_col_ack) begin
            col_got    <= 1'b1;
            ip_col_stb <= 1'b0;
          end
          // acks may land in different cycles; the current-cycle ack counts as latched
          if ((row_got || ip_row_ack) && (col_got || ip_col_ack))
            state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (ip_out_stb) begin
            res_data   <= ip_out;
            ip_out_ack <= 1'b0;
            res_we     <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (res_ready) begin
            res_we <= 1'b0;
            if (row_sel == IW'(N - 1) && col_sel == IW'(N - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // res_addr tracks i*N+j because the walk is row-major
              res_addr <= res_addr + 1'b1;
              if (col_sel == IW'(N - 1)) begin
                col_sel <= '0;
                row_sel <= row_sel + 1'b1;
              end else begin
                col_sel <= col_sel + 1'b1;
              end
              ip_row_stb <= 1'b1;
              ip_col_stb <= 1'b1;
              ip_out_ack <= 1'b1;
              row_got    <= 1'b0;
              col_got    <= 1'b0;
              state      <= ISSUE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef SCHED_TIMEOUT_EN
      // watchdog overrides any same-cycle progress and abandons the element unwritten
      if (state == ISSUE || state == WAIT_RES) begin
        if (cnt == CW'(TIMEOUT - 1)) begin
          ip_row_stb <= 1'b0;
          ip_col_stb <= 1'b0;
          ip_out_ack <= 1'b0;
          res_we     <= 1'b0;
          res_data   <= res_data;
          err        <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// tb/tb_matrix_mult_scheduler.sv - randomized engine/sink model and vector table for matrix_mult_scheduler
module tb_matrix_mult_scheduler;
  localparam int N = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err;
  logic [1:0]  row_sel, col_sel;
  logic        ip_row_stb, ip_col_stb, ip_row_ack, ip_col_ack;
  logic        ip_out_ack, ip_out_stb;
  logic [31:0] ip_out;
  logic        res_we;
  logic [3:0]  res_addr;
  logic [31:0] res_data;
  logic        res_ready;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int rl;
    int cl;
    int ol;
    int stall_elem;
    int stall_len;
    bit noise;
    int exp_cycles;
  } vec_t;

  vec_t vecs[6];

  matrix_mult_scheduler #(.N(N), .WORD_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .row_sel(row_sel), .col_sel(col_sel),
    .ip_row_stb(ip_row_stb), .ip_col_stb(ip_col_stb),
    .ip_row_ack(ip_row_ack), .ip_col_ack(ip_col_ack),
    .ip_out_ack(ip_out_ack), .ip_out_stb(ip_out_stb), .ip_out(ip_out),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // run length from the timing rules: ISSUE lasts max(ack latency)+1, WAIT_RES ol+1, WRITE stall+1
  function automatic int model_cycles(input vec_t v);
    int m;
    if (v.rl < 0 || v.cl < 0 || v.ol < 0 || v.stall_elem == -2) return -1;
    m = (v.rl > v.cl) ? v.rl : v.cl;
    return N * N * (m + v.ol + 3) + ((v.stall_elem >= 0) ? v.stall_len : 0) + 1;
  endfunction

  task automatic run_product(input vec_t v, input int abort_elem, input int hang_elem);
    int e, phase, rl, cl, ol, sl, rc, cc, oc, sc, iters, eiters, salt;
    bit active, rdone, cdone, fin, aborted, hung;
    logic [31:0] word;
    iters = 0; e = 0; phase = 0; eiters = 0;
    rl = 0; cl = 0; ol = 0; sl = 0; rc = 0; cc = 0; oc = 0; sc = 0;
    active = 0; rdone = 0; cdone = 0; fin = 0; aborted = 0; hung = 0;
    word = '0;
    salt = $urandom_range(0, 99);
    @(negedge clk);
    start = 1'b1;
    while (!fin) begin
      @(negedge clk);
      iters++;
      start = v.noise ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      ip_row_ack = 1'b0; ip_col_ack = 1'b0; ip_out_stb = 1'b0; ip_out = '0; res_ready = 1'b0;
      if (iters > 2000) begin
        checks++; failures++;
        $display("FAIL run_budget: actual=no done after %0d cycles required=done", iters);
        fin = 1;
      end else if (!active && e == N * N) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_at_done", 32'(err), 32'd0);
        if (v.exp_cycles > 0) check("run_cycles", 32'(iters), 32'(v.exp_cycles));
        fin = 1;
      end else if (!active && e == abort_elem) begin
        rst = 1'b1;
        aborted = 1;
        fin = 1;
      end else begin
        if (!active) begin
          check("new_row_stb", 32'(ip_row_stb), 32'd1);
          check("new_col_stb", 32'(ip_col_stb), 32'd1);
          rl = (v.rl < 0) ? $urandom_range(0, 4) : v.rl;
          cl = (v.cl < 0) ? $urandom_range(0, 4) : v.cl;
          ol = (v.ol < 0) ? $urandom_range(0, 4) : v.ol;
          if (e == hang_elem) ol = 1 << 30;
          sl = (v.stall_elem == -2) ? $urandom_range(0, v.stall_len) :
               (v.stall_elem == e) ? v.stall_len : 0;
          word = 32'((e / N) * 10 + (e % N) + salt * 1000);
          rc = 0; cc = 0; oc = 0; sc = 0; eiters = 0;
          rdone = 0; cdone = 0; phase = 0; active = 1;
        end
        if (phase < 2 && e == hang_elem && eiters == TMO) begin
          check("timeout_done", 32'(done), 32'd1);
          check("timeout_err", 32'(err), 32'd1);
          check("timeout_quiet", 32'({ip_row_stb, ip_col_stb, ip_out_ack, res_we, busy}), 32'd0);
          hung = 1;
          fin = 1;
        end else begin
          check("row_sel", 32'(row_sel), 32'(e / N));
          check("col_sel", 32'(col_sel), 32'(e % N));
          check("busy_run", 32'(busy), 32'd1);
          check("done_run", 32'(done), 32'd0);
          check("err_run", 32'(err), 32'd0);
          case (phase)
            0: begin
              check("issue_out_ack", 32'(ip_out_ack), 32'd1);
              check("issue_res_we", 32'(res_we), 32'd0);
              check("row_stb", 32'(ip_row_stb), 32'(!rdone));
              check("col_stb", 32'(ip_col_stb), 32'(!cdone));
              if (!rdone) begin
                if (rc == rl) begin ip_row_ack = 1'b1; rdone = 1; end else rc++;
              end else if (v.noise) ip_row_ack = 1'($urandom_range(0, 1));
              if (!cdone) begin
                if (cc == cl) begin ip_col_ack = 1'b1; cdone = 1; end else cc++;
              end else if (v.noise) ip_col_ack = 1'($urandom_range(0, 1));
              if (v.noise) begin
                ip_out_stb = 1'($urandom_range(0, 1));
                ip_out = 32'hdead_beef;
              end
              if (rdone && cdone) phase = 1;
              eiters++;
            end
            1: begin
              check("wait_out_ack", 32'(ip_out_ack), 32'd1);
              check("wait_quiet", 32'({ip_row_stb, ip_col_stb, res_we}), 32'd0);
              if (v.noise) begin
                ip_row_ack = 1'($urandom_range(0, 1));
                ip_col_ack = 1'($urandom_range(0, 1));
              end
              if (oc == ol) begin ip_out_stb = 1'b1; ip_out = word; phase = 2; end else oc++;
              eiters++;
            end
            default: begin
              check("write_we", 32'(res_we), 32'd1);
              check("write_addr", 32'(res_addr), 32'(e));
              check("write_data", res_data, word);
              check("write_quiet", 32'({ip_row_stb, ip_col_stb, ip_out_ack}), 32'd0);
              if (v.noise) begin
                ip_row_ack = 1'($urandom_range(0, 1));
                ip_col_ack = 1'($urandom_range(0, 1));
                ip_out_stb = 1'($urandom_range(0, 1));
                ip_out = 32'hbad0_cafe;
              end
              if (sc == sl) begin res_ready = 1'b1; e++; active = 0; end else sc++;
            end
          endcase
        end
      end
    end
    start = 1'b0;
    if (aborted) begin
      #1;
      check("abort_busy_done_err", 32'({busy, done, err}), 32'd0);
      check("abort_strobes", 32'({ip_row_stb, ip_col_stb, ip_out_ack, res_we}), 32'd0);
      check("abort_sel", 32'({row_sel, col_sel}), 32'd0);
      check("abort_addr", 32'(res_addr), 32'd0);
      check("abort_data", res_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("post_abort_idle", 32'({busy, done, res_we}), 32'd0);
      end
    end else begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      if (hung) check("err_held", 32'(err), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    ip_row_ack = 1'b0; ip_col_ack = 1'b0; ip_out_stb = 1'b0; ip_out = '0; res_ready = 1'b0;
    vecs[0] = '{0, 0, 0, -1, 0, 1'b0, 0};
    vecs[1] = '{0, 2, 5, -1, 0, 1'b0, 0};
    vecs[2] = '{3, 0, 1, 2, 7, 1'b0, 0};
    vecs[3] = '{-1, -1, -1, 2, 7, 1'b1, 0};
    vecs[4] = '{-1, -1, -1, -2, 3, 1'b1, 0};
    vecs[5] = '{0, 0, 0, 5, 7, 1'b1, 0};
    for (int k = 0; k < 6; k++) vecs[k].exp_cycles = model_cycles(vecs[k]);

    repeat (2) @(negedge clk);
    check("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
    check("rst_strobes", 32'({ip_row_stb, ip_col_stb, ip_out_ack, res_we}), 32'd0);
    check("rst_sel", 32'({row_sel, col_sel}), 32'd0);
    check("rst_addr_data", 32'(res_addr) | res_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_product(vecs[k], -1, -1);

    run_product(vecs[3], 3, -1);
    run_product(vecs[0], -1, -1);

`ifdef SCHED_TIMEOUT_EN
    run_product(vecs[0], -1, 1);
    run_product(vecs[4], -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
